// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the nibble-serial adder sequencer.
// The master side issues operations and the slave side is the sequencer.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, cin, op_a, op_b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, cin, op_a, op_b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built from one shared 4-bit ripple-carry slice, one nibble
// per clock, LSB nibble first, with the slice carry registered between cycles.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);
  localparam logic [W-1:0]  NIB_MASK = W'(4'hF);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;

  logic [IW+1:0] sh;
  logic [3:0]    a_nib, b_nib, s_nib;
  logic [4:0]    c;

  assign sh    = {idx_q, 2'b00};
  assign a_nib = 4'(a_q >> sh);
  assign b_nib = 4'(b_q >> sh);

  // Shared slice: four chained full adders; c[3] is the carry into the MSB bit.
  always_comb begin
    c     = '0;
    s_nib = '0;
    c[0]  = carry_q;
    for (int i = 0; i < 4; i++) begin
      s_nib[i] = a_nib[i] ^ b_nib[i] ^ c[i];
      c[i+1]   = (a_nib[i] & b_nib[i]) | (c[i] & (a_nib[i] ^ b_nib[i]));
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    b_d      = b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.op_a;
          b_d      = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d  = bus.sub ? 1'b1 : bus.cin;
          result_d = '0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d = (result_q & ~(NIB_MASK << sh)) | (W'(s_nib) << sh);
        carry_d  = c[4];
        if (idx_q == IDX_LAST) begin
          cout_d  = c[4];
          ovf_d   = c[3] ^ c[4];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand holding registers carry no control meaning, so they skip reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and randomized checks of the nibble-serial adder at 2, 4 and 16 nibbles.
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.NIBBLES(2))  if2 ();
  nibble_serial_adder_ctrl_if #(.NIBBLES(4))  if4 ();
  nibble_serial_adder_ctrl_if #(.NIBBLES(16)) if16 ();

  nibble_serial_adder_ctrl #(.NIBBLES(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  nibble_serial_adder_ctrl #(.NIBBLES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  nibble_serial_adder_ctrl #(.NIBBLES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference computed from signed/unsigned integer meaning of the operands.
  function automatic void ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic c,
                                 output logic [63:0] r, output logic co, output logic ov);
    logic [63:0]        mask;
    logic [65:0]        ua, ub, pw_u;
    logic signed [65:0] pw, sa, sb, tv;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    pw   = 66'sd1 <<< w;
    pw_u = $unsigned(pw);
    ua   = {2'b00, a & mask};
    ub   = {2'b00, b & mask};
    sa   = $signed(ua);
    sb   = $signed(ub);
    if (a[w-1]) sa = sa - pw;
    if (b[w-1]) sb = sb - pw;
    if (s) begin
      tv = sa - sb;
      co = (ua >= ub);
    end else begin
      tv = sa + sb + (c ? 66'sd1 : 66'sd0);
      co = ((ua + ub + {65'd0, c}) >= pw_u);
    end
    r  = tv[63:0] & mask;
    ov = (tv >= (pw >>> 1)) || (tv < -(pw >>> 1));
  endfunction

  // Waits for done on the 4-nibble instance; lat counts edges from the accepting one.
  task automatic wait_done4(output logic found, output int lat, output int bcnt);
    found = 1'b0;
    bcnt  = 0;
    lat   = 0;
    for (int t = 1; t <= 40 && !found; t++) begin
      if (if4.done) begin
        found = 1'b1;
        lat   = t;
      end else begin
        if (if4.busy) bcnt++;
        tick();
      end
    end
    chk("done_seen", {63'd0, found}, 64'd1);
  endtask

  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                      output logic [15:0] r, output logic co, output logic ov,
                      output int lat, output int bcnt);
    logic found;
    if4.op_a  = a;
    if4.op_b  = b;
    if4.sub   = s;
    if4.cin   = c;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    wait_done4(found, lat, bcnt);
    r  = if4.result;
    co = if4.cout;
    ov = if4.ovf;
    tick();
    chk("done_one_cycle", {63'd0, if4.done}, 64'd0);
  endtask

  initial begin
    logic [15:0] r;
    logic        co, ov, found;
    int          lat, bcnt, dcnt;
    logic [63:0] ra, rb, er, r2, r4, r16;
    logic        rs, rc, eco, eov;
    logic        co2, co4, co16, ov2, ov4, ov16, seen2, seen4, seen16;
    int          l2, l4, l16;

    if2.start = 0;  if2.sub = 0;  if2.cin = 0;  if2.op_a = '0;  if2.op_b = '0;
    if4.start = 0;  if4.sub = 0;  if4.cin = 0;  if4.op_a = '0;  if4.op_b = '0;
    if16.start = 0; if16.sub = 0; if16.cin = 0; if16.op_a = '0; if16.op_b = '0;

    tick();
    tick();
    chk("rst_busy",   {63'd0, if4.busy}, 64'd0);
    chk("rst_done",   {63'd0, if4.done}, 64'd0);
    chk("rst_result", {48'd0, if4.result}, 64'd0);
    chk("rst_cout",   {63'd0, if4.cout}, 64'd0);
    chk("rst_ovf",    {63'd0, if4.ovf}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Plain add with latency and busy-width checks
    run4(16'h1234, 16'h4321, 1'b0, 1'b0, r, co, ov, lat, bcnt);
    chk("add_latency", 64'(lat), 64'd5);
    chk("add_busy_cycles", 64'(bcnt), 64'd4);
    chk("add_result", {48'd0, r}, 64'h5555);
    chk("add_cout", {63'd0, co}, 64'd0);
    chk("add_ovf", {63'd0, ov}, 64'd0);
    chk("add_result_held", {48'd0, if4.result}, 64'h5555);

    // Carry ripple across every nibble
    run4(16'hFFFF, 16'h0000, 1'b0, 1'b1, r, co, ov, lat, bcnt);
    chk("ripple_result", {48'd0, r}, 64'h0000);
    chk("ripple_cout", {63'd0, co}, 64'd1);
    chk("ripple_ovf", {63'd0, ov}, 64'd0);

    // Subtraction with and without signed overflow
    run4(16'h8000, 16'h0001, 1'b1, 1'b0, r, co, ov, lat, bcnt);
    chk("sub_ovf_result", {48'd0, r}, 64'h7FFF);
    chk("sub_ovf_cout", {63'd0, co}, 64'd1);
    chk("sub_ovf_ovf", {63'd0, ov}, 64'd1);
    run4(16'h0003, 16'h0005, 1'b1, 1'b1, r, co, ov, lat, bcnt);
    chk("sub_neg_result", {48'd0, r}, 64'hFFFE);
    chk("sub_neg_cout", {63'd0, co}, 64'd0);
    chk("sub_neg_ovf", {63'd0, ov}, 64'd0);

    // Start held through RUN and DONE with other operands, then back-to-back start
    if4.op_a = 16'h1234; if4.op_b = 16'h4321; if4.sub = 1'b0; if4.cin = 1'b0;
    if4.start = 1'b1;
    tick();
    if4.op_a = 16'hFFFF; if4.op_b = 16'hFFFF; if4.sub = 1'b1; if4.cin = 1'b1;
    wait_done4(found, lat, bcnt);
    chk("busy_ignore_latency", 64'(lat), 64'd5);
    chk("busy_ignore_result", {48'd0, if4.result}, 64'h5555);
    chk("busy_ignore_cout", {63'd0, if4.cout}, 64'd0);
    if4.op_a = 16'h0003; if4.op_b = 16'h0005; if4.sub = 1'b1; if4.cin = 1'b0;
    tick();
    chk("after_done_idle_busy", {63'd0, if4.busy}, 64'd0);
    chk("after_done_idle_done", {63'd0, if4.done}, 64'd0);
    chk("after_done_result_held", {48'd0, if4.result}, 64'h5555);
    tick();
    if4.start = 1'b0;
    chk("b2b_accepted_busy", {63'd0, if4.busy}, 64'd1);
    chk("b2b_result_cleared", {48'd0, if4.result}, 64'h0000);
    wait_done4(found, lat, bcnt);
    chk("b2b_result", {48'd0, if4.result}, 64'hFFFE);
    chk("b2b_cout", {63'd0, if4.cout}, 64'd0);
    chk("b2b_ovf", {63'd0, if4.ovf}, 64'd0);
    tick();

    // Reset asserted during the second RUN cycle
    if4.op_a = 16'h1111; if4.op_b = 16'h2222; if4.sub = 1'b0; if4.cin = 1'b0;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    chk("mid_partial_result", {48'd0, if4.result}, 64'h0003);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, if4.busy}, 64'd0);
    chk("mid_rst_done", {63'd0, if4.done}, 64'd0);
    chk("mid_rst_result", {48'd0, if4.result}, 64'd0);
    chk("mid_rst_cout", {63'd0, if4.cout}, 64'd0);
    chk("mid_rst_ovf", {63'd0, if4.ovf}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int t = 0; t < 8; t++) begin
      if (if4.done || if4.busy) dcnt++;
      tick();
    end
    chk("mid_rst_no_done", 64'(dcnt), 64'd0);
    run4(16'h00FF, 16'h0001, 1'b0, 1'b0, r, co, ov, lat, bcnt);
    chk("post_rst_result", {48'd0, r}, 64'h0100);
    chk("post_rst_cout", {63'd0, co}, 64'd0);

    // Random operations on all three widths in parallel
    for (int n = 0; n < 3000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (n % 16 == 0) rb = ~ra;
      if (n % 16 == 1) ra = '1;
      if2.op_a = ra[7:0];   if2.op_b = rb[7:0];   if2.sub = rs;  if2.cin = rc;
      if4.op_a = ra[15:0];  if4.op_b = rb[15:0];  if4.sub = rs;  if4.cin = rc;
      if16.op_a = ra;       if16.op_b = rb;       if16.sub = rs; if16.cin = rc;
      if2.start = 1'b1; if4.start = 1'b1; if16.start = 1'b1;
      tick();
      if2.start = 1'b0; if4.start = 1'b0; if16.start = 1'b0;
      if2.op_a = ~ra[7:0]; if4.op_a = ~ra[15:0]; if16.op_a = ~ra;
      seen2 = 0; seen4 = 0; seen16 = 0;
      r2 = 'x; r4 = 'x; r16 = 'x;
      co2 = 1'bx; co4 = 1'bx; co16 = 1'bx; ov2 = 1'bx; ov4 = 1'bx; ov16 = 1'bx;
      l2 = 0; l4 = 0; l16 = 0;
      for (int t = 1; t <= 30 && !(seen2 && seen4 && seen16); t++) begin
        if (!seen2 && if2.done) begin
          seen2 = 1; l2 = t; r2 = {56'd0, if2.result}; co2 = if2.cout; ov2 = if2.ovf;
        end
        if (!seen4 && if4.done) begin
          seen4 = 1; l4 = t; r4 = {48'd0, if4.result}; co4 = if4.cout; ov4 = if4.ovf;
        end
        if (!seen16 && if16.done) begin
          seen16 = 1; l16 = t; r16 = if16.result; co16 = if16.cout; ov16 = if16.ovf;
        end
        tick();
      end
      ref_op(8, ra, rb, rs, rc, er, eco, eov);
      chk("rnd2_lat", 64'(l2), 64'd3);
      chk("rnd2_result", r2, er);
      chk("rnd2_cout", {63'd0, co2}, {63'd0, eco});
      chk("rnd2_ovf", {63'd0, ov2}, {63'd0, eov});
      ref_op(16, ra, rb, rs, rc, er, eco, eov);
      chk("rnd4_lat", 64'(l4), 64'd5);
      chk("rnd4_result", r4, er);
      chk("rnd4_cout", {63'd0, co4}, {63'd0, eco});
      chk("rnd4_ovf", {63'd0, ov4}, {63'd0, eov});
      ref_op(64, ra, rb, rs, rc, er, eco, eov);
      chk("rnd16_lat", 64'(l16), 64'd17);
      chk("rnd16_result", r16, er);
      chk("rnd16_cout", {63'd0, co16}, {63'd0, eco});
      chk("rnd16_ovf", {63'd0, ov16}, {63'd0, eov});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
